// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: opcode encoding, data widths
// and the arbiter state enum.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between NREQ requesters and the ALU arbiter.
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  import alu_pkg::*;

  // Both channels are valid/ready per requester: a transfer happens on a rising
  // edge where valid[i] and ready[i] are both high. Requesters may withdraw
  // req_valid at any time; the arbiter holds rsp_valid and data until accepted.
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][DATA_W-1:0] req_a;
  logic [NREQ-1:0][DATA_W-1:0] req_b;
  logic [NREQ-1:0][OP_W-1:0]   req_op;
  logic [NREQ-1:0]             rsp_valid;
  logic [NREQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]           rsp_result;
  logic                        rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU. Unused opcodes produce 0, so zero_o reads 1.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters; one operation
// in flight at a time, IDLE -> EXEC -> RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output arb_state_t       dbg_state_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        state_q;
  logic [IDX_W-1:0]  last_q;
  logic [IDX_W-1:0]  owner_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              busy_q;
  logic [CNT_W-1:0]  done_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [IDX_W-1:0]  grant;
  logic              any_valid;

  // Scan downward so the lowest offset from last+1 is the one that sticks;
  // the last grantee sits at offset NREQ and only wins when alone.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NREQ);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign any_valid = |bus.req_valid;
  assign grant     = rr_pick(bus.req_valid, last_q);

  assign bus.req_ready  = (state_q == IDLE && any_valid) ? (NREQ'(1) << grant) : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign busy           = busy_q;
  assign done_count     = done_q;
  assign dbg_state_o    = state_q;

  alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_q     <= bus.req_a[grant];
            b_q     <= bus.req_b[grant];
            op_q    <= bus.req_op[grant];
            owner_q <= grant;
            last_q  <= grant;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_result;
          zero_q      <= alu_zero;
          rsp_valid_q <= NREQ'(1) << owner_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= done_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model and a response scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int CNT_W = 16;
  localparam int IDX_W = $clog2(NREQ);
  localparam int EXP_W = 3 + DATA_W + 1;

  logic             clk;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] done_count;
  arb_state_t       dbg_state;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .done_count  (done_count),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference ALU, written from the opcode table
  function automatic logic [DATA_W:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r, r == 32'd0};
  endfunction

  // scoreboard: {owner, result, zero}
  logic [EXP_W-1:0] exp_q[$];
  int preload_seq = 0;

  // transaction model: arbitration, occupancy and completion count
  int               m_phase = 0;
  int               m_owner = 0;
  int               m_last  = NREQ - 1;
  logic [CNT_W-1:0] m_done  = '0;
  int               seen_seq = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0]  exp_ready;
    logic [NREQ-1:0]  exp_rsp;
    logic [IDX_W-1:0] gi;
    logic [DATA_W:0]  r;
    int g;
    int idx;
    if (preload_seq != seen_seq) begin
      seen_seq = preload_seq;
      m_done   = '1;
    end
    if (rst) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_done  = '0;
      exp_q.delete();
    end else begin
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (g < 0 && bus.req_valid[IDX_W'(idx)]) g = idx;
      end
      exp_ready = (m_phase == 0 && g >= 0) ? (NREQ'(1) << g) : '0;
      exp_rsp   = (m_phase == 2) ? (NREQ'(1) << m_owner) : '0;
      check("req_ready", bus.req_ready, exp_ready);
      check("busy", busy, m_phase != 0);
      check("rsp_valid", bus.rsp_valid, exp_rsp);
      check("done_count", done_count, m_done);
      if (m_phase == 0 && g >= 0) begin
        gi = IDX_W'(g);
        r = ref_alu(bus.req_a[gi], bus.req_b[gi], bus.req_op[gi]);
        exp_q.push_back({3'(g), r});
        m_owner = g;
        m_last  = g;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && bus.rsp_ready[IDX_W'(m_owner)]) begin
        m_done  = m_done + 1'b1;
        m_phase = 0;
      end
    end
  end

  // response monitor: pops on every response handshake, checks hold while stalled
  logic [DATA_W-1:0] hold_result;
  logic              hold_zero;
  logic              hold_v = 1'b0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("rsp_result_hold", bus.rsp_result, hold_result);
        check("rsp_zero_hold", bus.rsp_zero, hold_zero);
      end
      hold_v = 1'b0;
      if (bus.rsp_valid != '0) begin
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
          check("rsp_queue_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_owner", bus.rsp_valid, NREQ'(1) << e[EXP_W-1:DATA_W+1]);
            check("rsp_result", bus.rsp_result, e[DATA_W:1]);
            check("rsp_zero", bus.rsp_zero, e[0]);
          end
        end else begin
          hold_v      = 1'b1;
          hold_result = bus.rsp_result;
          hold_zero   = bus.rsp_zero;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input logic [IDX_W-1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[r] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_timeout", n < 60, 1);
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic send(input logic [IDX_W-1:0] r, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b1;
    bus.req_op[r]    = op;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    wait_ready(r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || bus.rsp_valid != '0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 60, 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", bus.rsp_result, 32'h0);
    check("reset_zero", bus.rsp_zero, 1'b0);
    check("reset_state", dbg_state, IDLE);

    // ADD overflow into the sign bit
    bus.rsp_ready = '1;
    send(1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    wait_idle();
    check("done_after_add", done_count, 16'd1);
    check("add_result", bus.rsp_result, 32'h8000_0000);

    // both requesters streaming: grants alternate
    @(posedge clk);
    #1;
    bus.req_op[0] = ALU_SUB; bus.req_a[0] = 32'd5;         bus.req_b[0] = 32'd5;
    bus.req_op[1] = ALU_SLT; bus.req_a[1] = 32'hFFFF_FFFF; bus.req_b[1] = 32'd1;
    bus.req_valid = '1;
    repeat (12) @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle();

    // stalled response from requester 1 while requester 0 waits
    send(1'b1, ALU_SRA, 32'h8000_0000, 32'd31);
    bus.rsp_ready = 2'b01;
    bus.req_op[0] = ALU_XOR; bus.req_a[0] = 32'h1234_5678; bus.req_b[0] = 32'h1234_5678;
    bus.req_valid[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sra_held_result", bus.rsp_result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 bus.rsp_ready = '1;
    wait_ready(1'b0);
    wait_idle();

    // unused opcode
    send(1'b0, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    check("op15_zero", bus.rsp_zero, 1'b1);

    // reset during EXEC aborts, then requester 0 has priority
    send(1'b1, ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done_count, 16'd0);
    @(posedge clk);
    #1 bus.req_valid = '1;
    @(negedge clk);
    check("grant_after_reset", bus.req_ready, 2'b01);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    wait_ready(1'b1);
    wait_idle();

    // counter wrap
    @(posedge clk);
    #1;
    force dut.done_q = 16'hFFFF;
    preload_seq++;
    #1 release dut.done_q;
    send(1'b0, ALU_SLTU, 32'd3, 32'd7);
    wait_idle();
    check("done_wrap", done_count, 16'd0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        bus.req_valid[IDX_W'(i)] = ($urandom_range(0, 2) != 0);
        bus.req_op[IDX_W'(i)]    = 4'($urandom_range(0, 15));
        bus.req_a[IDX_W'(i)]     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        bus.req_b[IDX_W'(i)]     = ($urandom_range(0, 3) == 0) ? bus.req_a[IDX_W'(i)] : $urandom;
      end
      bus.rsp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
